// File: rtl/pwm_bank.sv
// Memory-mapped multi-channel PWM generator with shadowed period/prescale/duty,
// per-channel enable and polarity, and a sticky wrap interrupt.
module pwm_bank #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         address_in,
  input  logic                sel_in,
  output logic [31:0]         read_value_out,
  input  logic [3:0]          write_mask_in,
  input  logic [31:0]         write_value_in,
  output logic                ready_out,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq_out
);

  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_PERIOD   = 6'h01;
  localparam logic [5:0] OFF_PRESCALE = 6'h02;
  localparam logic [5:0] OFF_STATUS   = 6'h03;
  localparam logic [5:0] OFF_POLARITY = 6'h04;
  localparam int         OFF_DUTY     = 16;

  function automatic logic [31:0] merge(input logic [31:0] old_value,
                                        input logic [31:0] new_value,
                                        input logic [31:0] mask);
    return (old_value & ~mask) | (new_value & mask);
  endfunction

  logic [5:0]                offset;
  logic                      wr_en;
  logic [31:0]               lane_mask;
  logic                      gen, irq_en;
  logic [CHANNELS-1:0]       cen, pol;
  logic [WIDTH-1:0]          period_pend, period_act, counter;
  logic [PRESCALE_WIDTH-1:0] presc_pend, presc_act, presc;
  logic                      wrap_flag, tick, wrap, load, wrap_clear;
  logic [31:0]               ctrl_word, period_word, presc_word, pol_word, counter_word;
  logic [31:0]               ctrl_new, period_new, presc_new, pol_new;
  logic [31:0]               rdata;
  logic [31:0]               duty_rd [CHANNELS];
  logic                      unused_bits;

  assign offset    = address_in[7:2];
  assign wr_en     = sel_in && (write_mask_in != 4'b0000);
  assign lane_mask = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                      {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
  assign ready_out = sel_in;

  always_comb begin
    ctrl_word                  = '0;
    ctrl_word[0]               = gen;
    ctrl_word[1]               = irq_en;
    ctrl_word[16 +: CHANNELS]  = cen;
    period_word                = '0;
    period_word[WIDTH-1:0]     = period_pend;
    presc_word                 = '0;
    presc_word[PRESCALE_WIDTH-1:0] = presc_pend;
    pol_word                   = '0;
    pol_word[CHANNELS-1:0]     = pol;
    counter_word               = '0;
    counter_word[WIDTH-1:0]    = counter;
    ctrl_new   = merge(ctrl_word,   write_value_in, lane_mask);
    period_new = merge(period_word, write_value_in, lane_mask);
    presc_new  = merge(presc_word,  write_value_in, lane_mask);
    pol_new    = merge(pol_word,    write_value_in, lane_mask);
  end

  assign unused_bits = ^{address_in[31:8], address_in[1:0], ctrl_new, period_new,
                         presc_new, pol_new, counter_word};

  assign tick       = gen && (presc == presc_act);
  assign wrap       = tick && (counter == period_act);
  assign load       = !gen || wrap;
  assign wrap_clear = wr_en && (offset == OFF_STATUS) && write_mask_in[0] && write_value_in[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen         <= 1'b0;
      irq_en      <= 1'b0;
      cen         <= '0;
      pol         <= '0;
      period_pend <= '0;
      presc_pend  <= '0;
    end else if (wr_en) begin
      if (offset == OFF_CTRL) begin
        gen    <= ctrl_new[0];
        irq_en <= ctrl_new[1];
        cen    <= ctrl_new[16 +: CHANNELS];
      end
      if (offset == OFF_PERIOD)   period_pend <= period_new[WIDTH-1:0];
      if (offset == OFF_PRESCALE) presc_pend  <= presc_new[PRESCALE_WIDTH-1:0];
      if (offset == OFF_POLARITY) pol         <= pol_new[CHANNELS-1:0];
    end
  end

  // Loads sample the pending value from before this edge, so a same-cycle write waits a period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_act <= '0;
      presc_act  <= '0;
      presc      <= '0;
      counter    <= '0;
    end else begin
      if (load) begin
        period_act <= period_pend;
        presc_act  <= presc_pend;
      end
      if (!gen) begin
        presc   <= '0;
        counter <= '0;
      end else if (tick) begin
        presc   <= '0;
        counter <= wrap ? '0 : counter + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_flag <= 1'b0;
      irq_out   <= 1'b0;
    end else begin
      if (wrap)            wrap_flag <= 1'b1;
      else if (wrap_clear) wrap_flag <= 1'b0;
      irq_out <= wrap_flag && irq_en;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] duty_pend, duty_act;
    logic [31:0]      duty_word, duty_new;
    logic             duty_hit, pwm_q, unused_duty;

    always_comb begin
      duty_word            = '0;
      duty_word[WIDTH-1:0] = duty_pend;
    end
    assign duty_new    = merge(duty_word, write_value_in, lane_mask);
    assign duty_hit    = wr_en && (offset == 6'(OFF_DUTY + gi));
    assign unused_duty = ^duty_new;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        duty_pend <= '0;
        duty_act  <= '0;
        pwm_q     <= 1'b0;
      end else begin
        if (duty_hit) duty_pend <= duty_new[WIDTH-1:0];
        if (load)     duty_act  <= duty_pend;
        pwm_q <= (gen && cen[gi] && (counter < duty_act)) ^ pol[gi];
      end
    end

    assign pwm_out[gi] = pwm_q;
    assign duty_rd[gi] = duty_word;
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL:     rdata = ctrl_word;
      OFF_PERIOD:   rdata = period_word;
      OFF_PRESCALE: rdata = presc_word;
      OFF_STATUS:   rdata = {counter_word[15:0], 15'b0, wrap_flag};
      OFF_POLARITY: rdata = pol_word;
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (offset == 6'(OFF_DUTY + i)) rdata = duty_rd[i];
        end
      end
    endcase
  end

  assign read_value_out = sel_in ? rdata : 32'h0;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: reset, duty, shadowing, limits, prescaler, interrupt.
module tb_pwm_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic        ready_out;
  logic [3:0]  pwm_out;
  logic        irq_out;

  int errors = 0;
  int checks = 0;

  pwm_bank #(.CHANNELS(4), .WIDTH(16), .PRESCALE_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in),
    .write_value_in(write_value_in), .ready_out(ready_out),
    .pwm_out(pwm_out), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic bus_idle();
    sel_in = 1'b0; address_in = '0; write_mask_in = '0; write_value_in = '0;
  endtask

  task automatic bus_drive_write(input logic [7:0] addr, input logic [31:0] data,
                                 input logic [3:0] mask);
    sel_in = 1'b1; address_in = {24'h0, addr}; write_mask_in = mask; write_value_in = data;
  endtask

  // Call at a negedge: write commits on the next posedge, returns at the following negedge.
  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] mask = 4'hF);
    bus_drive_write(addr, data, mask);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    sel_in = 1'b1; address_in = {24'h0, addr}; write_mask_in = '0;
    #1;
    data = read_value_out;
    bus_idle();
  endtask

  task automatic capture(input int ch, input int n, output logic [63:0] vec);
    vec = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      vec[k] = pwm_out[ch];
    end
  endtask

  logic [31:0] rd;
  logic [63:0] vec;

  initial begin
    bus_idle();
    // Reset held from time zero
    #12;
    check("rst_pwm", 64'(pwm_out), 64'h0);
    check("rst_irq", 64'(irq_out), 64'h0);
    bus_read(8'h0C, rd);
    check("rst_status", 64'(rd), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Byte lanes, unmapped offsets, select gating
    bus_write(8'h04, 32'h12345678, 4'b0011);
    bus_read(8'h04, rd);
    check("period_lanes01", 64'(rd), 64'h5678);
    bus_write(8'h04, 32'hFFFFFFAB, 4'b0001);
    bus_read(8'h04, rd);
    check("period_lane0", 64'(rd), 64'h56AB);
    bus_write(8'h20, 32'hFFFFFFFF);
    bus_read(8'h20, rd);
    check("unmapped_read", 64'(rd), 64'h0);
    sel_in = 1'b0; address_in = 32'h04;
    #1;
    check("nosel_read", 64'(read_value_out), 64'h0);
    check("nosel_ready", 64'(ready_out), 64'h0);
    sel_in = 1'b1;
    #1;
    check("sel_ready", 64'(ready_out), 64'h1);
    bus_idle();
    @(negedge clk);

    // Basic duty: period 9, duty 3
    bus_write(8'h04, 32'd9);
    bus_write(8'h08, 32'd0);
    bus_write(8'h40, 32'd3);
    bus_write(8'h00, 32'h0001_0001);
    check("basic_pre_edge", 64'(pwm_out[0]), 64'h0);
    capture(0, 20, vec);
    check("basic_wave", vec, 64'h0000_1C07);
    bus_read(8'h40, rd);
    check("duty0_read", 64'(rd), 64'h3);
    bus_read(8'h00, rd);
    check("ctrl_read", 64'(rd), 64'h0001_0001);

    // Shadow commit: mid-period write and wrap-cycle write
    @(negedge clk);
    bus_write(8'h00, 32'h0);
    bus_write(8'h40, 32'd3);
    bus_write(8'h00, 32'h0001_0001);
    vec = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      vec[k] = pwm_out[0];
      if (k == 4)       bus_drive_write(8'h40, 32'd7, 4'hF);
      else if (k == 18) bus_drive_write(8'h40, 32'd2, 4'hF);
      else              bus_idle();
    end
    check("shadow_wave", vec, 64'h0000_0000_C7F1_FC07);

    // Limits and polarity on channel 1
    bus_write(8'h00, 32'h0);
    bus_write(8'h44, 32'd0);
    bus_write(8'h00, 32'h0002_0001);
    capture(1, 12, vec);
    check("duty_zero", vec, 64'h0);
    bus_write(8'h00, 32'h0);
    bus_write(8'h44, 32'd10);
    bus_write(8'h00, 32'h0002_0001);
    capture(1, 12, vec);
    check("duty_over", vec, 64'hFFF);
    bus_write(8'h00, 32'h0);
    bus_write(8'h10, 32'h2);
    bus_write(8'h00, 32'h0002_0001);
    capture(1, 12, vec);
    check("duty_over_inv", vec, 64'h0);
    bus_write(8'h00, 32'h0);
    bus_write(8'h44, 32'd0);
    bus_write(8'h00, 32'h0002_0001);
    capture(1, 12, vec);
    check("duty_zero_inv", vec, 64'hFFF);
    bus_write(8'h00, 32'h0);
    bus_write(8'h44, 32'd5);
    bus_write(8'h00, 32'h0000_0001);
    capture(1, 12, vec);
    check("disabled_inv", vec, 64'hFFF);
    bus_write(8'h10, 32'h0);

    // Prescaler: prescale 2, period 3, duty 2
    bus_write(8'h00, 32'h0);
    bus_write(8'h04, 32'd3);
    bus_write(8'h08, 32'd2);
    bus_write(8'h40, 32'd2);
    bus_write(8'h00, 32'h0001_0001);
    capture(0, 24, vec);
    check("presc_wave", vec, 64'h3_F03F);
    @(negedge clk);
    bus_write(8'h00, 32'h0);
    bus_write(8'h00, 32'h0001_0001);
    vec = '0;
    for (int j = 0; j < 9; j++) begin
      bus_read(8'h0C, rd);
      vec[j*4 +: 4] = rd[19:16];
      @(negedge clk);
    end
    check("presc_counter", vec, 64'h2_2211_1000);

    // Interrupt: rise after wrap, set-wins on wrap cycle, off-wrap clear, masked lane
    bus_write(8'h00, 32'h0);
    bus_write(8'h08, 32'd0);
    bus_write(8'h04, 32'd3);
    bus_write(8'h0C, 32'h1, 4'b0001);
    bus_read(8'h0C, rd);
    check("wrap_cleared", 64'(rd[0]), 64'h0);
    bus_write(8'h00, 32'h0001_0003);
    vec = '0;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      vec[j] = irq_out;
      if (j == 6 || j == 8) bus_drive_write(8'h0C, 32'h1, 4'b0001);
      else if (j == 12)     bus_drive_write(8'h0C, 32'hFFFF_FFFF, 4'b0010);
      else                  bus_idle();
    end
    check("irq_wave", vec, 64'h3_F3F0);
    bus_read(8'h0C, rd);
    check("wrap_set", 64'(rd[0]), 64'h1);

    // Reset asserted mid-run
    @(negedge clk);
    check("pre_reset_irq", 64'(irq_out), 64'h1);
    reset = 1'b0;
    #1;
    check("midrst_pwm", 64'(pwm_out), 64'h0);
    check("midrst_irq", 64'(irq_out), 64'h0);
    bus_read(8'h0C, rd);
    check("midrst_status", 64'(rd), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(8'h00, rd);
    check("post_ctrl", 64'(rd), 64'h0);
    bus_read(8'h04, rd);
    check("post_period", 64'(rd), 64'h0);
    bus_read(8'h08, rd);
    check("post_prescale", 64'(rd), 64'h0);
    bus_read(8'h10, rd);
    check("post_polarity", 64'(rd), 64'h0);
    bus_read(8'h40, rd);
    check("post_duty0", 64'(rd), 64'h0);
    bus_read(8'h44, rd);
    check("post_duty1", 64'(rd), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
